tile_map_renderer: RTL and testbench
====================================

Name: tile_map_renderer

Overview:
- Parametrised, pipelined successor to the fixed-bitmap wall map.
- Holds a writable tile map (one TILE_BITS code per tile) plus a programmable 12-bit palette.
- Per pixel, adds a camera scroll offset, looks up the tile, and returns RGB and a solid flag with fixed latency.
- Sits between the VGA timing generator and the pixel mux; the game/physics logic updates tiles through a valid/ready write port.

Parameters:
- TILE_SHIFT, 3, log2 of tile edge in pixels (8x8 tiles).
- MAP_TILES_X, 80, map width in tiles.
- MAP_TILES_Y, 60, map height in tiles.
- TILE_BITS, 2, bits per tile code; palette has 2^TILE_BITS entries.
- ADDR_W, 13, write-address width; must be >= clog2(MAP_TILES_X*MAP_TILES_Y).
- BORDER_TILES, 1, thickness in tiles of the solid frame written by INIT.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- pix_x  in  10  screen x
- pix_y  in  10  screen y
- pix_valid  in  1  pix_x/pix_y valid this cycle
- frame_start  in  1  one-cycle pulse at frame start; latches scroll
- scroll_x  in  10  camera x offset, world pixels
- scroll_y  in  10  camera y offset, world pixels
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_sel  in  1  0 = tile memory, 1 = palette
- wr_addr  in  ADDR_W  tile index (y*MAP_TILES_X+x), or palette index in the low TILE_BITS
- wr_data  in  12  tile code in the low TILE_BITS, or RGB444 palette colour
- rgb_valid  out  1  pix_valid delayed 3 cycles
- rgb  out  12  pixel colour
- solid  out  1  pixel lies in a nonzero tile or outside the map
- init_busy  out  1  INIT sequence in progress

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- Reset values: rgb=12'hFFF, rgb_valid=0, solid=0, wr_ready=0, init_busy=1, scroll registers=0, pipeline valids=0.
- Palette reset: entry0=12'hFFF, entry1=12'h000, others=12'h000.
- FSM INIT:
  - Address counter runs 0..N-1 (N=MAP_TILES_X*MAP_TILES_Y), one write per cycle.
  - Writes code 1 when tile col<BORDER_TILES or col>=MAP_TILES_X-BORDER_TILES or row<BORDER_TILES or row>=MAP_TILES_Y-BORDER_TILES; otherwise code 0.
  - Track col/row with counters; no divider.
  - After address N-1, go to RUN. INIT lasts exactly N cycles after rst deasserts.
  - During INIT: wr_ready=0, init_busy=1. Pipeline outputs rgb=12'hFFF, solid=0, and rgb_valid still tracks pix_valid.
- FSM RUN: wr_ready=1 continuously. init_busy=0.
- rst asserted in any state: return to INIT with the counter at 0, and reload palette defaults.
- Scroll: scroll_x/scroll_y are sampled only on frame_start. A change mid-frame has no effect until the next pulse.
- Pipeline (latency 3):
  - S1: wx=pix_x+sx, wy=pix_y+sy, 11-bit, no wrap. tx=wx>>TILE_SHIFT, ty=wy>>TILE_SHIFT. oob=(tx>=MAP_TILES_X)||(ty>=MAP_TILES_Y).
  - S2: synchronous read of tile memory at ty*MAP_TILES_X+tx.
  - S3: palette lookup.
  - Output: rgb=oob?12'h000:palette[code]; solid=oob||(code!=0).
- Tile memory: simple dual-port block RAM, read-first. A write and read of the same address in one cycle returns the old code; the new code is visible from the next cycle.
- Palette writes take effect in S3 from the cycle after the accept.
- Out-of-range tile writes (wr_addr>=N) are accepted and dropped.
- Write data bits above TILE_BITS are ignored for tile writes.

Optional Feature:
- Macro: TILE_MAP_GRID_EN.
- Defined: in-map pixels with wx[TILE_SHIFT-1:0]==0 or wy[TILE_SHIFT-1:0]==0 output rgb=12'h888. solid is unchanged; OOB pixels are unaffected. Adds one pipeline bit, and latency stays 3.
- Undefined: no grid, and the output is as specified above.

Test Plan:
- Release rst, hold pix_valid=1 -> init_busy high for exactly 4800 cycles. Afterwards wr_ready=1; tile(0,0)=1, tile(1,1)=0, tile(79,59)=1.
- After INIT, scroll=0, pix=(4,4) -> 3 cycles later rgb=12'h000, solid=1. pix=(100,100) -> rgb=12'hFFF, solid=0.
- Write tile 10*80+20=820 with code 2, palette[2]=12'hF00, then drive pix=(160,80) -> rgb=12'hF00, solid=1.
- Set scroll_x=5 without frame_start, pix=(155,80) -> unchanged white. After a frame_start pulse, same pixel -> 12'hF00.
- scroll_x=1000, pix=(0,100) -> wx>=640 -> rgb=12'h000, solid=1 (OOB).
- Assert rst at INIT count 2000 -> init_busy stays 1, INIT restarts, and a full 4800 cycles are required after release. The palette reads back defaults.

Source files
------------

// File: rtl/tile_map_renderer.sv
// Scrolling tile-map renderer: writable tile RAM plus palette, three-stage pixel pipeline.
// Optional macro TILE_MAP_GRID_EN overlays a grey grid on in-map tile edges.
module tile_map_renderer #(
  parameter int TILE_SHIFT   = 3,
  parameter int MAP_TILES_X  = 80,
  parameter int MAP_TILES_Y  = 60,
  parameter int TILE_BITS    = 2,
  parameter int ADDR_W       = 13,
  parameter int BORDER_TILES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              pix_valid,
  input  logic              frame_start,
  input  logic [9:0]        scroll_x,
  input  logic [9:0]        scroll_y,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              wr_sel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [11:0]       wr_data,
  output logic              rgb_valid,
  output logic [11:0]       rgb,
  output logic              solid,
  output logic              init_busy
);

  localparam int N     = MAP_TILES_X * MAP_TILES_Y;
  localparam int PAL_N = 1 << TILE_BITS;

  localparam logic [ADDR_W-1:0] N_A      = ADDR_W'(N);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(MAP_TILES_X - 1);
  localparam logic [ADDR_W-1:0] B_LO     = ADDR_W'(BORDER_TILES);
  localparam logic [ADDR_W-1:0] BX_HI    = ADDR_W'(MAP_TILES_X - BORDER_TILES);
  localparam logic [ADDR_W-1:0] BY_HI    = ADDR_W'(MAP_TILES_Y - BORDER_TILES);
  localparam logic [10:0]       MX       = 11'(MAP_TILES_X);
  localparam logic [10:0]       MY       = 11'(MAP_TILES_Y);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, col_q, row_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:    if (cnt_q == LAST) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) begin
        cnt_q <= cnt_q + ADDR_W'(1);
        if (col_q == LAST_COL) begin
          col_q <= '0;
          row_q <= row_q + ADDR_W'(1);
        end else begin
          col_q <= col_q + ADDR_W'(1);
        end
      end
    end
  end

  assign init_busy = (state_q == INIT);
  assign wr_ready  = (state_q == RUN);

  logic                 border;
  logic                 we;
  logic [ADDR_W-1:0]    waddr;
  logic [TILE_BITS-1:0] wcode;

  assign border = (col_q < B_LO) || (col_q >= BX_HI) ||
                  (row_q < B_LO) || (row_q >= BY_HI);

  // INIT owns the write port; afterwards out-of-range tile writes are dropped
  always_comb begin
    we    = 1'b0;
    waddr = cnt_q;
    wcode = TILE_BITS'(border);
    if (init_busy) begin
      we = 1'b1;
    end else if (wr_valid && !wr_sel && (wr_addr < N_A)) begin
      we    = 1'b1;
      waddr = wr_addr;
      wcode = wr_data[TILE_BITS-1:0];
    end
  end

  logic [11:0] pal_q [PAL_N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PAL_N; i++)
        pal_q[i] <= (i == 0) ? 12'hFFF : 12'h000;
    end else if (wr_valid && wr_ready && wr_sel) begin
      pal_q[wr_addr[TILE_BITS-1:0]] <= wr_data;
    end
  end

  logic [9:0] sx_q, sy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sx_q <= '0;
      sy_q <= '0;
    end else if (frame_start) begin
      sx_q <= scroll_x;
      sy_q <= scroll_y;
    end
  end

  logic [10:0]       wx, wy, tx, ty;
  logic              oob;
  logic [ADDR_W-1:0] idx;

  assign wx  = {1'b0, pix_x} + {1'b0, sx_q};
  assign wy  = {1'b0, pix_y} + {1'b0, sy_q};
  assign tx  = wx >> TILE_SHIFT;
  assign ty  = wy >> TILE_SHIFT;
  assign oob = (tx >= MX) || (ty >= MY);
  assign idx = oob ? '0 : ADDR_W'(ty) * ADDR_W'(MAP_TILES_X) + ADDR_W'(tx);

  logic              s1_v, s1_oob, s2_v, s2_oob;
  logic [ADDR_W-1:0] s1_idx;
  logic [TILE_BITS-1:0] s2_code;
  logic [TILE_BITS-1:0] mem [N];

  // Read-first RAM: same-cycle read of a written address sees the old code
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wcode;
    s2_code <= mem[s1_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_oob <= 1'b0;
      s1_idx <= '0;
      s2_v   <= 1'b0;
      s2_oob <= 1'b0;
    end else begin
      s1_v   <= pix_valid;
      s1_oob <= oob;
      s1_idx <= idx;
      s2_v   <= s1_v;
      s2_oob <= s1_oob;
    end
  end

  logic [11:0] colour;

`ifdef TILE_MAP_GRID_EN
  logic grid, s1_grid, s2_grid;

  assign grid = (wx[TILE_SHIFT-1:0] == '0) || (wy[TILE_SHIFT-1:0] == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_grid <= 1'b0;
      s2_grid <= 1'b0;
    end else begin
      s1_grid <= grid;
      s2_grid <= s1_grid;
    end
  end

  assign colour = s2_grid ? 12'h888 : pal_q[s2_code];
`else
  assign colour = pal_q[s2_code];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_valid <= 1'b0;
      rgb       <= 12'hFFF;
      solid     <= 1'b0;
    end else begin
      rgb_valid <= s2_v;
      if (init_busy) begin
        rgb   <= 12'hFFF;
        solid <= 1'b0;
      end else if (s2_oob) begin
        rgb   <= 12'h000;
        solid <= 1'b1;
      end else begin
        rgb   <= colour;
        solid <= (s2_code != '0);
      end
    end
  end

endmodule

// File: tb/tb_tile_map_renderer.sv
// Bench for tile_map_renderer: arithmetic map model checked every cycle
// plus directed probes with hand-computed colours.
module tb_tile_map_renderer;

  localparam int N = 4800;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  pix_x = '0, pix_y = '0;
  logic        pix_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  scroll_x = '0, scroll_y = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic        wr_sel = 1'b0;
  logic [12:0] wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        rgb_valid;
  logic [11:0] rgb;
  logic        solid;
  logic        init_busy;

  tile_map_renderer dut (
    .clk(clk), .rst(rst),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .frame_start(frame_start), .scroll_x(scroll_x), .scroll_y(scroll_y),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rgb_valid(rgb_valid), .rgb(rgb), .solid(solid),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit v;
    int x, y, sx, sy;
  } px_t;

  int          m_tile [N];
  logic [11:0] m_pal  [4];
  int          m_sx, m_sy, m_cnt;
  px_t         p0, p1;
  bit          e_v, e_solid, chk_en;
  logic [11:0] e_rgb;

  function automatic void expect_px(input px_t p, output logic [11:0] r,
                                    output bit s);
    int wx, wy, tx, ty, code;
    wx = p.x + p.sx;
    wy = p.y + p.sy;
    tx = wx / 8;
    ty = wy / 8;
    if (tx >= 80 || ty >= 60) begin
      r = 12'h000;
      s = 1'b1;
    end else begin
      code = m_tile[ty * 80 + tx];
      s = (code != 0);
      r = m_pal[code];
`ifdef TILE_MAP_GRID_EN
      if (wx % 8 == 0 || wy % 8 == 0) r = 12'h888;
`endif
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_tile[i] = (i % 80 == 0 || i % 80 == 79 ||
                     i / 80 == 0 || i / 80 == 59) ? 1 : 0;
      end
      m_pal[0] = 12'hFFF;
      m_pal[1] = 12'h000;
      m_pal[2] = 12'h000;
      m_pal[3] = 12'h000;
      m_sx = 0;
      m_sy = 0;
      m_cnt = 0;
      p0.v = 0;
      p1.v = 0;
      e_v = 0;
      e_rgb = 12'hFFF;
      e_solid = 0;
      chk_en = 1;
    end else begin
      e_v = p1.v;
      if (m_cnt < N) begin
        e_rgb = 12'hFFF;
        e_solid = 0;
      end else begin
        expect_px(p1, e_rgb, e_solid);
      end
      p1 = p0;
      p0.v = pix_valid;
      p0.x = int'(pix_x);
      p0.y = int'(pix_y);
      p0.sx = m_sx;
      p0.sy = m_sy;
      if (frame_start) begin
        m_sx = int'(scroll_x);
        m_sy = int'(scroll_y);
      end
      if (wr_valid && m_cnt >= N) begin
        if (wr_sel) m_pal[wr_addr[1:0]] = wr_data;
        else if (int'(wr_addr) < N) m_tile[wr_addr] = int'(wr_data[1:0]);
      end
      if (m_cnt < N) m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (rgb_valid !== e_v) begin
        n_bad++;
        $display("FAIL rgb_valid: got %b want %b t=%0t", rgb_valid, e_v, $time);
      end
      n_cmp++;
      if (init_busy !== (m_cnt < N) || wr_ready !== (m_cnt >= N)) begin
        n_bad++;
        $display("FAIL init_busy/wr_ready: got %b/%b want %b t=%0t",
                 init_busy, wr_ready, m_cnt < N, $time);
      end
      if (e_v) begin
        n_cmp++;
        if (rgb !== e_rgb || solid !== e_solid) begin
          n_bad++;
          $display("FAIL model pixel: got rgb=%h solid=%b want rgb=%h solid=%b t=%0t",
                   rgb, solid, e_rgb, e_solid, $time);
        end
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic probe(input string name, input int x, input int y,
                       input logic [11:0] er, input logic es);
    @(negedge clk);
    pix_x = 10'(x);
    pix_y = 10'(y);
    pix_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    lit({name, " rgb"}, 32'(rgb), 32'(er));
    lit({name, " solid"}, 32'(solid), 32'(es));
  endtask

  task automatic wr(input logic sel, input int addr, input logic [11:0] d);
    @(negedge clk);
    pix_valid = 1'b0;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_sel = sel;
    wr_addr = 13'(addr);
    wr_data = d;
    #1 lit("wr_ready", 32'(wr_ready), 32'd1);
    @(negedge clk);
    wr_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_scroll(input int sx, input int sy);
    @(negedge clk);
    scroll_x = 10'(sx);
    scroll_y = 10'(sy);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic count_init(input string name);
    int n;
    n = 0;
    while (init_busy === 1'b1 && n < 6000) begin
      @(posedge clk);
      #1 n++;
    end
    lit(name, 32'(n), 32'd4800);
  endtask

  initial begin
    chk_en = 0;
    pix_valid = 1'b1;
    repeat (3) @(negedge clk);
    lit("reset rgb", 32'(rgb), 32'hFFF);
    lit("reset busy", 32'(init_busy), 32'd1);
    lit("reset wr_ready", 32'(wr_ready), 32'd0);
    rst = 1'b0;
    count_init("init cycles");
    @(negedge clk);
    lit("run wr_ready", 32'(wr_ready), 32'd1);

    probe("tile00", 4, 4, 12'h000, 1'b1);
    probe("tile11", 12, 12, 12'hFFF, 1'b0);
    probe("tile7959", 636, 476, 12'h000, 1'b1);
    probe("open", 100, 100, 12'hFFF, 1'b0);

    wr(1'b0, 820, 12'h002);
    wr(1'b1, 2, 12'hF00);
    wr(1'b0, 821, 12'hFFE);
    wr(1'b0, 4800, 12'h003);
    probe("tile820", 161, 81, 12'hF00, 1'b1);
    probe("tile821 hi bits", 169, 81, 12'hF00, 1'b1);

    @(negedge clk);
    scroll_x = 10'd5;
    probe("scroll held", 156, 81, 12'hFFF, 1'b0);
    pulse_scroll(5, 0);
    probe("scroll taken", 156, 81, 12'hF00, 1'b1);

    pulse_scroll(1000, 0);
    probe("oob", 0, 100, 12'h000, 1'b1);
    pulse_scroll(1, 0);
    probe("edge in map", 630, 100, 12'hFFF, 1'b0);

    pulse_scroll(0, 0);
    wr(1'b1, 0, 12'h0F0);
    probe("pal0 green", 100, 100, 12'h0F0, 1'b0);

    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2000) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    lit("mid reset busy", 32'(init_busy), 32'd1);
    rst = 1'b0;
    count_init("reinit cycles");
    probe("pal0 default", 100, 100, 12'hFFF, 1'b0);
    probe("tile820 cleared", 161, 81, 12'hFFF, 1'b0);
    probe("tile00 again", 4, 4, 12'h000, 1'b1);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
